// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with generic width/depth (non-power-of-two allowed),
// programmable almost-full/almost-empty thresholds and an optional FWFT read mode.
module sync_fifo_prog #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 8,
   parameter int AF_THRESH  = DEPTH - 1,
   parameter int AE_THRESH  = 1,
   parameter int FWFT       = 0,
   localparam int CW        = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  wr_en,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  rd_valid,
   output logic                  wr_ack,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  full,
   output logic                  empty,
   output logic                  almostfull,
   output logic                  almostempty,
   output logic [CW-1:0]         count
);

   localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

   if (DEPTH < 2) begin : g_bad_depth
      $fatal(1, "sync_fifo_prog: DEPTH must be >= 2");
   end
   if (AF_THRESH < 1 || AF_THRESH > DEPTH - 1) begin : g_bad_af
      $fatal(1, "sync_fifo_prog: AF_THRESH out of range");
   end
   if (AE_THRESH < 1 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
      $fatal(1, "sync_fifo_prog: AE_THRESH out of range");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic                  wr_acc;
   logic                  rd_acc;

   assign full        = (count == CW'(DEPTH));
   assign empty       = (count == '0);
   assign almostfull  = (count >= CW'(AF_THRESH)) && !full;
   assign almostempty = !empty && (count <= CW'(AE_THRESH));

   assign wr_acc = wr_en && !full;
   assign rd_acc = rd_en && !empty;

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         wr_ack    <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         end
         if (rd_acc) begin
            rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         end
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         wr_ack    <= wr_acc;
         overflow  <= wr_en && full;
         underflow <= rd_en && empty;
      end
   end

   if (FWFT != 0) begin : g_fwft
      // Head word is presented straight from storage; zero while empty.
      assign data_out = empty ? '0 : mem[rd_ptr];
      assign rd_valid = !empty;
   end else begin : g_std
      logic [DATA_WIDTH-1:0] data_q;
      logic                  valid_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
         end else begin
            valid_q <= rd_acc;
            if (rd_acc) begin
               data_q <= mem[rd_ptr];
            end
         end
      end

      assign data_out = data_q;
      assign rd_valid = valid_q;
   end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: unit 0 = DEPTH 8 (AF 6, AE 2), unit 1 = DEPTH 5,
// unit 2 = DEPTH 4 in FWFT mode.
module tb_sync_fifo_prog;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   logic [15:0] a_din, a_dout;
   logic        a_wr, a_rd, a_rv, a_ack, a_ov, a_un, a_full, a_empty, a_af, a_ae;
   logic [3:0]  a_cnt;

   logic [15:0] b_din, b_dout;
   logic        b_wr, b_rd, b_rv, b_ack, b_ov, b_un, b_full, b_empty, b_af, b_ae;
   logic [2:0]  b_cnt;

   logic [15:0] c_din, c_dout;
   logic        c_wr, c_rd, c_rv, c_ack, c_ov, c_un, c_full, c_empty, c_af, c_ae;
   logic [2:0]  c_cnt;

   sync_fifo_prog #(.DATA_WIDTH(16), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) u_a (
      .clk(clk), .rst(rst), .data_in(a_din), .wr_en(a_wr), .rd_en(a_rd),
      .data_out(a_dout), .rd_valid(a_rv), .wr_ack(a_ack), .overflow(a_ov),
      .underflow(a_un), .full(a_full), .empty(a_empty), .almostfull(a_af),
      .almostempty(a_ae), .count(a_cnt));

   sync_fifo_prog #(.DATA_WIDTH(16), .DEPTH(5), .FWFT(0)) u_b (
      .clk(clk), .rst(rst), .data_in(b_din), .wr_en(b_wr), .rd_en(b_rd),
      .data_out(b_dout), .rd_valid(b_rv), .wr_ack(b_ack), .overflow(b_ov),
      .underflow(b_un), .full(b_full), .empty(b_empty), .almostfull(b_af),
      .almostempty(b_ae), .count(b_cnt));

   sync_fifo_prog #(.DATA_WIDTH(16), .DEPTH(4), .FWFT(1)) u_c (
      .clk(clk), .rst(rst), .data_in(c_din), .wr_en(c_wr), .rd_en(c_rd),
      .data_out(c_dout), .rd_valid(c_rv), .wr_ack(c_ack), .overflow(c_ov),
      .underflow(c_un), .full(c_full), .empty(c_empty), .almostfull(c_af),
      .almostempty(c_ae), .count(c_cnt));

   int bq[$];
   int bNext = 1;

   // Drive one unit for a single clock, idle the others, and return at the next falling edge.
   task automatic applyStimulus(input int unit, input logic wr, input logic rd, input logic [15:0] din);
      a_wr = 1'b0; a_rd = 1'b0; a_din = '0;
      b_wr = 1'b0; b_rd = 1'b0; b_din = '0;
      c_wr = 1'b0; c_rd = 1'b0; c_din = '0;
      case (unit)
         0:       begin a_wr = wr; a_rd = rd; a_din = din; end
         1:       begin b_wr = wr; b_rd = rd; b_din = din; end
         default: begin c_wr = wr; c_rd = rd; c_din = din; end
      endcase
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Queue-backed helpers for the DEPTH=5 unit.
   task automatic bWrite(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1, 1'b1, 1'b0, 16'(bNext));
         bq.push_back(bNext);
         bNext++;
         checkOutput("b_wr_ack", 32'(b_ack), 32'd1);
         checkOutput("b_count_w", 32'(b_cnt), 32'(bq.size()));
         checkOutput("b_full_w", 32'(b_full), 32'(bq.size() == 5));
         checkOutput("b_af_w", 32'(b_af), 32'(bq.size() == 4));
      end
   endtask

   task automatic bRead(input int n);
      int exp;
      for (int i = 0; i < n; i++) begin
         applyStimulus(1, 1'b0, 1'b1, 16'h0);
         exp = bq.pop_front();
         checkOutput("b_rd_valid", 32'(b_rv), 32'd1);
         checkOutput("b_data", 32'(b_dout), 32'(exp));
         checkOutput("b_count_r", 32'(b_cnt), 32'(bq.size()));
         checkOutput("b_full_r", 32'(b_full), 32'(bq.size() == 5));
      end
   endtask

   initial begin
      rst = 1'b1;
      a_wr = 1'b0; a_rd = 1'b0; a_din = '0;
      b_wr = 1'b0; b_rd = 1'b0; b_din = '0;
      c_wr = 1'b0; c_rd = 1'b0; c_din = '0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_count", 32'(a_cnt), 32'd0);
      checkOutput("rst_empty", 32'(a_empty), 32'd1);
      checkOutput("rst_full", 32'(a_full), 32'd0);
      checkOutput("rst_af", 32'(a_af), 32'd0);
      checkOutput("rst_ae", 32'(a_ae), 32'd0);
      checkOutput("rst_data", 32'(a_dout), 32'd0);
      checkOutput("rst_valid", 32'(a_rv), 32'd0);
      checkOutput("rst_pulses", 32'({a_ack, a_ov, a_un}), 32'd0);
      checkOutput("rst_c_valid", 32'(c_rv), 32'd0);
      rst = 1'b0;

      // Fill unit 0 with 1..8, then overflow it.
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(0, 1'b1, 1'b0, 16'(i));
         checkOutput("fill_ack", 32'(a_ack), 32'd1);
         checkOutput("fill_count", 32'(a_cnt), 32'(i));
         checkOutput("fill_full", 32'(a_full), 32'(i == 8));
         checkOutput("fill_af", 32'(a_af), 32'(i == 6 || i == 7));
         checkOutput("fill_ae", 32'(a_ae), 32'(i == 1 || i == 2));
      end
      applyStimulus(0, 1'b1, 1'b0, 16'hDEAD);
      checkOutput("ovf_flag", 32'(a_ov), 32'd1);
      checkOutput("ovf_ack", 32'(a_ack), 32'd0);
      checkOutput("ovf_count", 32'(a_cnt), 32'd8);
      applyStimulus(0, 1'b0, 1'b0, 16'h0);
      checkOutput("ovf_clear", 32'(a_ov), 32'd0);

      for (int i = 1; i <= 8; i++) begin
         applyStimulus(0, 1'b0, 1'b1, 16'h0);
         checkOutput("drain_valid", 32'(a_rv), 32'd1);
         checkOutput("drain_data", 32'(a_dout), 32'(i));
         checkOutput("drain_count", 32'(a_cnt), 32'(8 - i));
         checkOutput("drain_af", 32'(a_af), 32'(i == 1 || i == 2));
         checkOutput("drain_ae", 32'(a_ae), 32'(i == 6 || i == 7));
      end
      checkOutput("drain_empty", 32'(a_empty), 32'd1);
      applyStimulus(0, 1'b0, 1'b0, 16'h0);
      checkOutput("idle_valid", 32'(a_rv), 32'd0);
      checkOutput("idle_hold", 32'(a_dout), 32'd8);

      applyStimulus(0, 1'b0, 1'b1, 16'h0);
      checkOutput("udf_flag", 32'(a_un), 32'd1);
      checkOutput("udf_valid", 32'(a_rv), 32'd0);
      checkOutput("udf_count", 32'(a_cnt), 32'd0);

      // Both requests on empty: only the write lands.
      applyStimulus(0, 1'b1, 1'b1, 16'h0100);
      checkOutput("both_empty_udf", 32'(a_un), 32'd1);
      checkOutput("both_empty_ack", 32'(a_ack), 32'd1);
      checkOutput("both_empty_valid", 32'(a_rv), 32'd0);
      checkOutput("both_empty_count", 32'(a_cnt), 32'd1);
      for (int i = 1; i <= 3; i++) applyStimulus(0, 1'b1, 1'b0, 16'(16'h0100 + i));
      checkOutput("pre_both_count", 32'(a_cnt), 32'd4);

      for (int k = 0; k < 10; k++) begin
         applyStimulus(0, 1'b1, 1'b1, 16'(16'h0104 + k));
         checkOutput("both_count", 32'(a_cnt), 32'd4);
         checkOutput("both_data", 32'(a_dout), 32'(16'h0100 + k));
         checkOutput("both_ack", 32'(a_ack), 32'd1);
      end
      for (int k = 0; k < 4; k++) applyStimulus(0, 1'b1, 1'b0, 16'(16'h010E + k));
      checkOutput("refill_full", 32'(a_full), 32'd1);

      // Both requests on full: only the read lands.
      applyStimulus(0, 1'b1, 1'b1, 16'h0BAD);
      checkOutput("both_full_ovf", 32'(a_ov), 32'd1);
      checkOutput("both_full_ack", 32'(a_ack), 32'd0);
      checkOutput("both_full_data", 32'(a_dout), 32'h010A);
      checkOutput("both_full_count", 32'(a_cnt), 32'd7);

      for (int k = 0; k < 5; k++) begin
         applyStimulus(0, 1'b0, 1'b1, 16'h0);
         checkOutput("tail_data", 32'(a_dout), 32'(16'h010B + k));
      end
      applyStimulus(0, 1'b1, 1'b0, 16'h0055);
      checkOutput("pre_rst_count", 32'(a_cnt), 32'd3);
      checkOutput("pre_rst_ack", 32'(a_ack), 32'd1);

      // Asynchronous reset between edges with wr_en still high.
      #2 rst = 1'b1;
      #1;
      checkOutput("arst_count", 32'(a_cnt), 32'd0);
      checkOutput("arst_empty", 32'(a_empty), 32'd1);
      checkOutput("arst_ack", 32'(a_ack), 32'd0);
      checkOutput("arst_data", 32'(a_dout), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(0, 1'b0, 1'b1, 16'h0);
      checkOutput("post_rst_udf", 32'(a_un), 32'd1);
      checkOutput("post_rst_valid", 32'(a_rv), 32'd0);
      applyStimulus(0, 1'b1, 1'b0, 16'h0077);
      checkOutput("post_rst_ack", 32'(a_ack), 32'd1);
      checkOutput("post_rst_count", 32'(a_cnt), 32'd1);
      applyStimulus(0, 1'b0, 1'b1, 16'h0);
      checkOutput("post_rst_data", 32'(a_dout), 32'h0077);

      // DEPTH=5: 12 words through several pointer wraps.
      bWrite(5);
      applyStimulus(1, 1'b1, 1'b0, 16'hDEAD);
      checkOutput("b_ovf", 32'(b_ov), 32'd1);
      checkOutput("b_ovf_count", 32'(b_cnt), 32'd5);
      bRead(3);
      bWrite(3);
      bRead(5);
      checkOutput("b_empty", 32'(b_empty), 32'd1);
      bWrite(4);
      bRead(4);
      checkOutput("b_total", 32'(bNext), 32'd13);

      // FWFT unit.
      applyStimulus(2, 1'b1, 1'b0, 16'h00A5);
      checkOutput("c_fall_data", 32'(c_dout), 32'h00A5);
      checkOutput("c_fall_valid", 32'(c_rv), 32'd1);
      applyStimulus(2, 1'b0, 1'b0, 16'h0);
      checkOutput("c_hold_data", 32'(c_dout), 32'h00A5);
      applyStimulus(2, 1'b1, 1'b0, 16'h00B6);
      applyStimulus(2, 1'b1, 1'b0, 16'h00C7);
      checkOutput("c_head_stays", 32'(c_dout), 32'h00A5);
      checkOutput("c_count3", 32'(c_cnt), 32'd3);
      applyStimulus(2, 1'b0, 1'b1, 16'h0);
      checkOutput("c_pop1", 32'(c_dout), 32'h00B6);
      applyStimulus(2, 1'b0, 1'b1, 16'h0);
      checkOutput("c_pop2", 32'(c_dout), 32'h00C7);
      checkOutput("c_pop2_valid", 32'(c_rv), 32'd1);
      applyStimulus(2, 1'b0, 1'b1, 16'h0);
      checkOutput("c_pop3_valid", 32'(c_rv), 32'd0);
      checkOutput("c_pop3_empty", 32'(c_empty), 32'd1);
      applyStimulus(2, 1'b0, 1'b1, 16'h0);
      checkOutput("c_udf", 32'(c_un), 32'd1);
      checkOutput("c_udf_valid", 32'(c_rv), 32'd0);
      for (int i = 1; i <= 4; i++) applyStimulus(2, 1'b1, 1'b0, 16'(i));
      checkOutput("c_full", 32'(c_full), 32'd1);
      checkOutput("c_full_head", 32'(c_dout), 32'd1);
      applyStimulus(2, 1'b1, 1'b1, 16'h0099);
      checkOutput("c_both_full_ovf", 32'(c_ov), 32'd1);
      checkOutput("c_both_full_data", 32'(c_dout), 32'd2);
      checkOutput("c_both_full_count", 32'(c_cnt), 32'd3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
